// File: rtl/dfflr_pipe_pkg.sv
// rtl/dfflr_pipe_pkg.sv - shared sizing helper for the elastic pipeline register
//
// Purpose : holds the width rule for the occupancy counter so the top and any
//           wrapper agree on it.
// Ports   : none (package).

package dfflr_pipe_pkg;

  // Width needed to count 0..depth inclusive; never narrower than one bit.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dfflr_pipe_stage.sv
// rtl/dfflr_pipe_stage.sv - one valid/ready stage: valid flop plus load-enabled data register
//
// Purpose : a single elastic register slice. Accepts a word whenever it is empty
//           or its own word is leaving downstream in the same cycle.
// Ports   :
//   clk       in   1    rising-edge clock
//   rst_n     in   1    asynchronous reset, active low
//   flush     in   1    synchronous clear of the valid bit, blocks loading
//   up_valid  in   1    upstream word valid
//   up_data   in   DW   upstream word
//   up_ready  out  1    stage can take up_data this cycle (combinational)
//   dn_valid  out  1    stage holds a valid word
//   dn_data   out  DW   held word
//   dn_ready  in   1    downstream takes dn_data this cycle

module dfflr_pipe_stage
  import dfflr_pipe_pkg::*;
#(
  parameter int unsigned          DW      = 8,
  parameter logic [DW-1:0]        RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          dn_valid,
  output logic [DW-1:0] dn_data,
  input  logic          dn_ready
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_advance;
  logic          w_load;

  // Room exists if empty, or if the current word leaves on this same edge.
  assign up_ready  = ~r_valid | dn_ready;

  // flush overrides any movement; the valid bit just follows upstream otherwise.
  assign w_advance = up_ready & ~flush;
  assign w_load    = w_advance & up_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= up_valid;
    end
  end

  // Data only moves on a real load, so bubbles and flushes leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= RST_VAL;
    end else if (w_load) begin
      r_data <= up_data;
    end
  end

  assign dn_valid = r_valid;
  assign dn_data  = r_data;

endmodule

// File: rtl/dfflr_pipe.sv
// rtl/dfflr_pipe.sv - DEPTH-stage elastic pipeline register with flush and occupancy
//
// Purpose : retimes a DW-bit datapath through DEPTH register stages without
//           breaking back-pressure. Bubbles collapse under stall, full
//           throughput when out_ready is held high.
// Ports   :
//   clk        in   1                rising-edge clock
//   rst_n      in   1                asynchronous reset, active low
//   flush      in   1                synchronous clear of all valid bits
//   in_valid   in   1                upstream data valid
//   in_ready   out  1                pipeline accepts in_data this cycle
//   in_data    in   DW               upstream data
//   out_valid  out  1                last stage holds valid data
//   out_ready  in   1                downstream accepts out_data this cycle
//   out_data   out  DW               last stage data
//   occupancy  out  occ_width(DEPTH) number of valid stages, 0..DEPTH

module dfflr_pipe
  import dfflr_pipe_pkg::*;
#(
  parameter int unsigned   DW      = 8,
  parameter int unsigned   DEPTH   = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DW-1:0]                  in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW-1:0]                  out_data,
  output logic [occ_width(DEPTH)-1:0]    occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  // Index k is the link feeding stage k; index DEPTH is the output port.
  logic [DEPTH:0]  w_valid;
  logic [DW-1:0]   w_data  [DEPTH+1];
  logic            w_ready [DEPTH+1];
  logic [OCC_W-1:0] w_occ;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign w_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dfflr_pipe_stage #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (w_valid[k]),
      .up_data  (w_data[k]),
      .up_ready (w_ready[k]),
      .dn_valid (w_valid[k+1]),
      .dn_data  (w_data[k+1]),
      .dn_ready (w_ready[k+1])
    );
  end

  // Stage 0 already refuses to load under flush; masking here keeps the
  // upstream handshake honest so the sender does not count a dropped word.
  assign in_ready  = w_ready[0] & ~flush;
  assign out_valid = w_valid[DEPTH];
  assign out_data  = w_data[DEPTH];

  always_comb begin
    w_occ = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(w_valid[k]);
    end
  end

  assign occupancy = w_occ;

endmodule
